// File: rtl/solver_scheduler.sv
// Round-robin scheduler sharing one solver datapath among four requesters, with
// launch, timeout-abort and solver reset sequencing; all outputs are registered.
module solver_scheduler #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] x_in,
    output logic [3:0]  gnt,
    output logic        solver_start,
    output logic        solver_rst,
    output logic [7:0]  solver_x,
    input  logic        solver_done,
    input  logic [15:0] solver_y,
    output logic [15:0] y_out,
    output logic [3:0]  y_valid,
    output logic [3:0]  err,
    output logic        busy,
    output logic [2:0]  dbg_state
);
    // Handshake: req[i] is held high until the matching one-cycle y_valid[i] or
    // err[i] pulse; the run completes even if req[i] drops while granted.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3,
        S_ABORT  = 3'd4,
        S_CLEAR  = 3'd5
    } state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  own_q, own_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  solver_x_q, solver_x_d;
    logic [15:0] y_out_q, y_out_d;
    logic [3:0]  y_valid_q, y_valid_d;
    logic [3:0]  err_q, err_d;
    logic        solver_start_q, solver_start_d;
    logic        solver_rst_q, solver_rst_d;
    logic        busy_q, busy_d;

    logic        win_found;
    logic [1:0]  win_idx;
    logic [7:0]  cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        logic [1:0] idx;
        win_found = 1'b0;
        win_idx   = ptr_q + 2'd1;
        idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i + 1);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            gnt_q          <= 4'd0;
            own_q          <= 2'd0;
            ptr_q          <= 2'd3;
            cnt_q          <= 8'd0;
            solver_x_q     <= 8'd0;
            y_out_q        <= 16'd0;
            y_valid_q      <= 4'd0;
            err_q          <= 4'd0;
            solver_start_q <= 1'b0;
            solver_rst_q   <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            own_q          <= own_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            solver_x_q     <= solver_x_d;
            y_out_q        <= y_out_d;
            y_valid_q      <= y_valid_d;
            err_q          <= err_d;
            solver_start_q <= solver_start_d;
            solver_rst_q   <= solver_rst_d;
            busy_q         <= busy_d;
        end
    end

    // cnt_inc is the 1-based index of the current WAIT cycle, so the abort
    // pulse lands exactly TIMEOUT cycles after solver_start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (win_found) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (solver_done)          state_d = S_RESP;
                else if (cnt_inc == LAST) state_d = S_ABORT;
            end
            S_RESP:   state_d = S_CLEAR;
            S_ABORT:  state_d = S_CLEAR;
            S_CLEAR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d          = gnt_q;
        own_d          = own_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        solver_x_d     = solver_x_q;
        y_out_d        = y_out_q;
        solver_start_d = (state_d == S_LAUNCH);
        solver_rst_d   = (state_d == S_CLEAR);
        busy_d         = (state_d != S_IDLE);
        y_valid_d      = (state_d == S_RESP)  ? gnt_q : 4'd0;
        err_d          = (state_d == S_ABORT) ? gnt_q : 4'd0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d      = 4'b0001 << win_idx;
                    own_d      = win_idx;
                    solver_x_d = x_in[{win_idx, 3'b000} +: 8];
                end
            end
            S_LAUNCH: cnt_d = 8'd0;
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (solver_done) y_out_d = solver_y;
            end
            S_RESP, S_ABORT: ptr_d = own_q;
            S_CLEAR: gnt_d = 4'd0;
            default: ;
        endcase
    end

    assign gnt          = gnt_q;
    assign solver_start = solver_start_q;
    assign solver_rst   = solver_rst_q | rst;
    assign solver_x     = solver_x_q;
    assign y_out        = y_out_q;
    assign y_valid      = y_valid_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_solver_scheduler.sv
// Directed bench for solver_scheduler: reset, single run, round-robin order,
// timeout, done/timeout collision, reset mid-run and operand stability.
module tb_solver_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] x_in;
    logic [3:0]  gnt;
    logic        solver_start;
    logic        solver_rst;
    logic [7:0]  solver_x;
    logic        solver_done;
    logic [15:0] solver_y;
    logic [15:0] y_out;
    logic [3:0]  y_valid;
    logic [3:0]  err;
    logic        busy;
    logic [2:0]  dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    solver_scheduler #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .x_in(x_in), .gnt(gnt),
        .solver_start(solver_start), .solver_rst(solver_rst), .solver_x(solver_x),
        .solver_done(solver_done), .solver_y(solver_y), .y_out(y_out),
        .y_valid(y_valid), .err(err), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs set afterwards are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'd0; x_in = 32'd0; solver_done = 1'b0; solver_y = 16'd0;
        step();
        step();
        tests_run++; if (gnt !== 4'd0) begin tests_failed++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (y_out !== 16'd0) begin tests_failed++; $display("FAIL reset_y_out got=%h exp=0000", y_out); end
        tests_run++; if (solver_x !== 8'd0) begin tests_failed++; $display("FAIL reset_solver_x got=%h exp=00", solver_x); end
        tests_run++; if ({y_valid, err, solver_start} !== 9'd0) begin tests_failed++; $display("FAIL reset_pulses got=%b exp=0", {y_valid, err, solver_start}); end
        tests_run++; if (solver_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_solver_rst got=%b exp=1", solver_rst); end
        tests_run++; if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        rst = 1'b0;
        step();
        step();
        tests_run++; if (solver_rst !== 1'b0) begin tests_failed++; $display("FAIL post_reset_solver_rst got=%b exp=0", solver_rst); end
    endtask

    // One complete run starting from an IDLE cycle with req/x_in already set.
    task automatic do_run(input string name, input logic [3:0] exp_gnt, input logic [7:0] exp_x,
                          input int lat, input logic [15:0] yv, input bit drop_req);
        logic [31:0] x_save;
        x_save = x_in;
        step();
        tests_run++; if (gnt !== exp_gnt) begin tests_failed++; $display("FAIL %s_gnt got=%b exp=%b", name, gnt, exp_gnt); end
        tests_run++; if (solver_x !== exp_x) begin tests_failed++; $display("FAIL %s_solver_x got=%h exp=%h", name, solver_x, exp_x); end
        tests_run++; if (solver_start !== 1'b1) begin tests_failed++; $display("FAIL %s_start got=%b exp=1", name, solver_start); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL %s_busy got=%b exp=1", name, busy); end
        for (int j = 1; j <= lat; j++) begin
            x_in = ~x_in;
            step();
            if (drop_req && j == 2) req = 4'd0;
            if (j == lat) begin solver_done = 1'b1; solver_y = yv; end
            tests_run++; if (solver_start !== 1'b0) begin tests_failed++; $display("FAIL %s_start_pulse cyc=%0d got=%b exp=0", name, j, solver_start); end
            tests_run++; if ({y_valid, err} !== 8'd0) begin tests_failed++; $display("FAIL %s_early_pulse cyc=%0d got=%b exp=0", name, j, {y_valid, err}); end
            tests_run++; if (solver_x !== exp_x) begin tests_failed++; $display("FAIL %s_x_stable cyc=%0d got=%h exp=%h", name, j, solver_x, exp_x); end
        end
        x_in = x_save;
        step();
        solver_done = 1'b0;
        tests_run++; if (y_valid !== exp_gnt) begin tests_failed++; $display("FAIL %s_y_valid got=%b exp=%b", name, y_valid, exp_gnt); end
        tests_run++; if (y_out !== yv) begin tests_failed++; $display("FAIL %s_y_out got=%h exp=%h", name, y_out, yv); end
        tests_run++; if (err !== 4'd0) begin tests_failed++; $display("FAIL %s_err got=%b exp=0000", name, err); end
        step();
        tests_run++; if (solver_rst !== 1'b1) begin tests_failed++; $display("FAIL %s_solver_rst got=%b exp=1", name, solver_rst); end
        tests_run++; if (y_valid !== 4'd0) begin tests_failed++; $display("FAIL %s_y_valid_width got=%b exp=0000", name, y_valid); end
        step();
        tests_run++; if (gnt !== 4'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL %s_idle got gnt=%b busy=%b exp gnt=0000 busy=0", name, gnt, busy); end
        tests_run++; if (solver_rst !== 1'b0) begin tests_failed++; $display("FAIL %s_solver_rst_off got=%b exp=0", name, solver_rst); end
    endtask

    task automatic test_round_robin();
        req = 4'b1111; x_in = 32'h44332211;
        do_run("rr0", 4'b0001, 8'h11, 3, 16'h1000, 1'b0);
        do_run("rr1", 4'b0010, 8'h22, 3, 16'h1001, 1'b0);
        do_run("rr2", 4'b0100, 8'h33, 3, 16'h1002, 1'b0);
        do_run("rr3", 4'b1000, 8'h44, 3, 16'h1003, 1'b0);
        do_run("rr4", 4'b0001, 8'h11, 3, 16'h1004, 1'b0);
        req = 4'd0;
    endtask

    task automatic test_single();
        req = 4'b0001; x_in = 32'h000000_05;
        do_run("single", 4'b0001, 8'h05, 6, 16'h0042, 1'b1);
        req = 4'd0;
    endtask

    task automatic test_done_ignored();
        req = 4'd0; solver_done = 1'b1; solver_y = 16'hdead;
        for (int j = 0; j < 3; j++) begin
            step();
            tests_run++; if (busy !== 1'b0 || gnt !== 4'd0 || y_valid !== 4'd0) begin tests_failed++; $display("FAIL done_in_idle got busy=%b gnt=%b y_valid=%b exp 0", busy, gnt, y_valid); end
        end
        solver_done = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        req = 4'b0100; x_in = 32'h00ab0000;
        step();
        tests_run++; if (gnt !== 4'b0100 || solver_start !== 1'b1) begin tests_failed++; $display("FAIL to_launch got gnt=%b start=%b exp gnt=0100 start=1", gnt, solver_start); end
        for (int j = 1; j <= 15; j++) begin
            step();
            tests_run++; if ({y_valid, err} !== 8'd0 || busy !== 1'b1) begin tests_failed++; $display("FAIL to_wait cyc=%0d got vld_err=%b busy=%b exp 0/1", j, {y_valid, err}, busy); end
        end
        step();
        req = 4'b1001;
        tests_run++; if (err !== 4'b0100) begin tests_failed++; $display("FAIL to_err got=%b exp=0100", err); end
        tests_run++; if (y_valid !== 4'd0) begin tests_failed++; $display("FAIL to_y_valid got=%b exp=0000", y_valid); end
        tests_run++; if (y_out !== 16'h0042) begin tests_failed++; $display("FAIL to_y_out_held got=%h exp=0042", y_out); end
        step();
        tests_run++; if (solver_rst !== 1'b1 || err !== 4'd0) begin tests_failed++; $display("FAIL to_clear got rst=%b err=%b exp 1/0000", solver_rst, err); end
        step();
        tests_run++; if (gnt !== 4'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL to_idle got gnt=%b busy=%b exp 0000/0", gnt, busy); end
        x_in = 32'h77000066;
        do_run("to_next", 4'b1000, 8'h77, 1, 16'h0777, 1'b0);
        req = 4'd0;
    endtask

    task automatic test_collision();
        req = 4'b0010; x_in = 32'h0000_5a00;
        step();
        tests_run++; if (gnt !== 4'b0010) begin tests_failed++; $display("FAIL col_gnt got=%b exp=0010", gnt); end
        for (int j = 1; j <= 15; j++) begin
            step();
            if (j == 15) begin solver_done = 1'b1; solver_y = 16'hbeef; end
            tests_run++; if ({y_valid, err} !== 8'd0) begin tests_failed++; $display("FAIL col_wait cyc=%0d got=%b exp=0", j, {y_valid, err}); end
        end
        step();
        solver_done = 1'b0; req = 4'd0;
        tests_run++; if (y_valid !== 4'b0010) begin tests_failed++; $display("FAIL col_y_valid got=%b exp=0010", y_valid); end
        tests_run++; if (err !== 4'd0) begin tests_failed++; $display("FAIL col_err got=%b exp=0000", err); end
        tests_run++; if (y_out !== 16'hbeef) begin tests_failed++; $display("FAIL col_y_out got=%h exp=beef", y_out); end
        step();
        step();
    endtask

    task automatic test_reset_mid_run();
        req = 4'b0001; x_in = 32'h000000c3;
        step();
        step();
        step();
        tests_run++; if (dbg_state !== 3'd2) begin tests_failed++; $display("FAIL rmr_in_wait got=%0d exp=2", dbg_state); end
        rst = 1'b1;
        step();
        tests_run++; if (gnt !== 4'd0 || busy !== 1'b0 || solver_x !== 8'd0) begin tests_failed++; $display("FAIL rmr_outputs got gnt=%b busy=%b x=%h exp 0", gnt, busy, solver_x); end
        tests_run++; if ({y_valid, err, solver_start} !== 9'd0 || y_out !== 16'd0) begin tests_failed++; $display("FAIL rmr_pulses got=%b y_out=%h exp 0", {y_valid, err, solver_start}, y_out); end
        tests_run++; if (solver_rst !== 1'b1) begin tests_failed++; $display("FAIL rmr_solver_rst got=%b exp=1", solver_rst); end
        rst = 1'b0; req = 4'b1001; x_in = 32'h990000c3;
        step();
        tests_run++; if (gnt !== 4'b0001 || solver_x !== 8'hc3) begin tests_failed++; $display("FAIL rmr_regrant got gnt=%b x=%h exp 0001/c3", gnt, solver_x); end
        tests_run++; if ({y_valid, err} !== 8'd0) begin tests_failed++; $display("FAIL rmr_no_resp got=%b exp=0", {y_valid, err}); end
        req = 4'b1000; rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        tests_run++; if (gnt !== 4'b1000) begin tests_failed++; $display("FAIL rmr_gnt3 got=%b exp=1000", gnt); end
        req = 4'd0; rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_done_ignored();
        test_timeout();
        test_collision();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
